axi_read_arbiter: RTL

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

---
 rtl/axi_read_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/axi_read_arbiter.sv
// Two-port read arbiter: round-robin between instruction-fetch and data-load
// requesters, issuing one AXI4-Lite read at a time and returning the data.
module axi_read_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            i_Clock,
  input  logic            i_Reset_N,
  input  logic            i_Req_Valid_0,
  input  logic            i_Req_Valid_1,
  input  logic [XLEN-1:0] i_Req_Addr_0,
  input  logic [XLEN-1:0] i_Req_Addr_1,
  output logic            o_Grant_0,
  output logic            o_Grant_1,
  output logic            o_Resp_Valid_0,
  output logic            o_Resp_Valid_1,
  output logic [XLEN-1:0] o_Resp_Data,
  output logic            o_Resp_Err,
  output logic            o_Busy_0,
  output logic            o_Busy_1,
  output logic [31:0]     m_axil_araddr,
  output logic            m_axil_arvalid,
  input  logic            m_axil_arready,
  input  logic [31:0]     m_axil_rdata,
  input  logic [1:0]      m_axil_rresp,
  input  logic            m_axil_rvalid,
  output logic            m_axil_rready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t          state_reg;
  logic            owner_reg;
  logic            favour_reg;
  logic            active_reg;
  logic [31:0]     addr_reg;
  logic            arvalid_reg;
  logic            rready_reg;
  logic [1:0]      resp_valid_reg;
  logic [XLEN-1:0] resp_data_reg;
  logic            resp_err_reg;

  logic [1:0]      req_valid;
  logic [31:0]     req_addr [2];
  logic [1:0]      grant;
  logic [1:0]      busy;
  logic            any_req;
  logic            winner;

  assign req_valid   = {i_Req_Valid_1, i_Req_Valid_0};
  assign req_addr[0] = i_Req_Addr_0[31:0];
  assign req_addr[1] = i_Req_Addr_1[31:0];
  assign any_req     = |req_valid;

  // On a tie the favoured port wins; a lone requester wins outright.
  assign winner = (&req_valid) ? favour_reg : req_valid[1];

  // Grant is issued in the IDLE cycle itself so the address is captured on
  // the same edge; it is masked while reset is held.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign grant[gi] = i_Reset_N && (state_reg == ST_IDLE) &&
                         req_valid[gi] && (winner == 1'(gi));
      assign busy[gi]  = grant[gi] | (active_reg && (owner_reg == 1'(gi)));
    end
  endgenerate

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= 1'b0;
      favour_reg     <= 1'b0;
      active_reg     <= 1'b0;
      addr_reg       <= '0;
      arvalid_reg    <= 1'b0;
      rready_reg     <= 1'b0;
      resp_valid_reg <= '0;
      resp_data_reg  <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      resp_valid_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            owner_reg   <= winner;
            favour_reg  <= ~winner;
            addr_reg    <= req_addr[winner];
            active_reg  <= 1'b1;
            arvalid_reg <= 1'b1;
            state_reg   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_axil_arready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (m_axil_rvalid) begin
            rready_reg                <= 1'b0;
            resp_data_reg             <= XLEN'(m_axil_rdata);
            resp_err_reg              <= |m_axil_rresp;
            resp_valid_reg[owner_reg] <= 1'b1;
            state_reg                 <= ST_RESP;
          end
        end
        ST_RESP: begin
          active_reg <= 1'b0;
          state_reg  <= ST_IDLE;
        end
        default: begin
          active_reg  <= 1'b0;
          arvalid_reg <= 1'b0;
          rready_reg  <= 1'b0;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_Grant_0      = grant[0];
  assign o_Grant_1      = grant[1];
  assign o_Busy_0       = busy[0];
  assign o_Busy_1       = busy[1];
  assign o_Resp_Valid_0 = resp_valid_reg[0];
  assign o_Resp_Valid_1 = resp_valid_reg[1];
  assign o_Resp_Data    = resp_data_reg;
  assign o_Resp_Err     = resp_err_reg;
  assign m_axil_araddr  = addr_reg;
  assign m_axil_arvalid = arvalid_reg;
  assign m_axil_rready  = rready_reg;

endmodule
